// File: rtl/tk1_led_pwm.sv
// tk1_led_pwm: per-channel 8-bit PWM with blink/breathe patterns and a CPU-trap
// red blink override, driving the RGB driver PWM inputs. Small tk1-style register window.
module tk1_led_pwm #(
   parameter int PRESCALE    = 16,
   parameter int TRAP_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  led_en,
   input  logic        cpu_trap,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b
);

   localparam int              TW         = (TRAP_FRAMES > 1) ? $clog2(TRAP_FRAMES) : 1;
   localparam logic [15:0]     PRESC_LAST = 16'(PRESCALE - 1);
   localparam logic [TW-1:0]   TRAP_LAST  = TW'(TRAP_FRAMES - 1);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_DUTY   = 8'h01;
   localparam logic [7:0] ADDR_BLINK  = 8'h02;
   localparam logic [7:0] ADDR_STATUS = 8'h03;

   typedef enum logic [1:0] {
      MODE_SOLID   = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_SOLID3  = 2'd3
   } mode_e;

   logic [15:0]   presc_q, presc_d;
   logic [7:0]    pwm_ctr_q, pwm_ctr_d;
   logic [23:0]   duty_reg_q, duty_reg_d;
   logic [23:0]   duty_act_q, duty_act_d;
   mode_e         mode_q, mode_d;
   logic [7:0]    blink_q, blink_d;
   logic [7:0]    blink_ctr_q, blink_ctr_d;
   logic          blink_phase_q, blink_phase_d;
   logic [7:0]    level_q, level_d;
   logic          ramp_down_q, ramp_down_d;
   logic [TW-1:0] trap_ctr_q, trap_ctr_d;
   logic          trap_phase_q, trap_phase_d;
   logic [2:0]    pwm_q, pwm_d;

   logic          tick;
   logic          frame_end;
   logic          wr;
   logic [7:0]    blink_last;
   logic [7:0]    eff [3];
   logic [15:0]   prod [3];
   logic [2:0]    on;
   logic          unused_wdata;

   assign unused_wdata = &{1'b0, write_data[31:24]};

   assign tick       = (presc_q == PRESC_LAST);
   assign frame_end  = tick && (pwm_ctr_q == 8'hFF);
   assign wr         = cs && we;
   assign blink_last = (blink_q == 8'd0) ? 8'd0 : blink_q - 8'd1;
   assign ready      = cs;

   always_comb begin
      presc_d       = tick ? 16'd0 : presc_q + 16'd1;
      pwm_ctr_d     = tick ? pwm_ctr_q + 8'd1 : pwm_ctr_q;
      duty_reg_d    = duty_reg_q;
      duty_act_d    = frame_end ? duty_reg_q : duty_act_q;
      mode_d        = mode_q;
      blink_d       = blink_q;
      blink_ctr_d   = blink_ctr_q;
      blink_phase_d = blink_phase_q;
      level_d       = level_q;
      ramp_down_d   = ramp_down_q;
      trap_ctr_d    = trap_ctr_q;
      trap_phase_d  = trap_phase_q;

      if (wr && address == ADDR_DUTY)  duty_reg_d = write_data[23:0];
      if (wr && address == ADDR_BLINK) blink_d    = write_data[7:0];

      if (frame_end) begin
         if (blink_ctr_q == blink_last) begin
            blink_ctr_d   = 8'd0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_ctr_d = blink_ctr_q + 8'd1;
         end
         // Triangle: hold one frame at each end while the direction flips.
         if (!ramp_down_q) begin
            if (level_q == 8'hFF) ramp_down_d = 1'b1;
            else                  level_d     = level_q + 8'd1;
         end else begin
            if (level_q == 8'h00) ramp_down_d = 1'b0;
            else                  level_d     = level_q - 8'd1;
         end
      end

      // A mode change restarts the pattern, overriding any same-cycle frame update.
      if (wr && address == ADDR_CTRL) begin
         mode_d        = mode_e'(write_data[1:0]);
         blink_ctr_d   = 8'd0;
         blink_phase_d = 1'b0;
         level_d       = 8'd0;
         ramp_down_d   = 1'b0;
      end

      if (!cpu_trap) begin
         trap_ctr_d   = '0;
         trap_phase_d = 1'b0;
      end else if (frame_end) begin
         if (trap_ctr_q == TRAP_LAST) begin
            trap_ctr_d   = '0;
            trap_phase_d = ~trap_phase_q;
         end else begin
            trap_ctr_d = trap_ctr_q + 1'b1;
         end
      end
   end

   // Channel index 0=b, 1=g, 2=r matches both led_en and the DUTY byte order.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         prod[i] = 16'(duty_act_q[8*i +: 8]) * 16'(level_q);
         case (mode_q)
            MODE_BLINK:   eff[i] = blink_phase_q ? 8'd0 : duty_act_q[8*i +: 8];
            MODE_BREATHE: eff[i] = prod[i][15:8];
            default:      eff[i] = duty_act_q[8*i +: 8];
         endcase
         on[i] = led_en[i] && (pwm_ctr_q < eff[i]);
      end
      pwm_d = cpu_trap ? {trap_phase_q, 2'b00} : on;
   end

   always_comb begin
      read_data = 32'd0;
      if (cs && !we) begin
         case (address)
            ADDR_CTRL:   read_data = {30'd0, mode_q};
            ADDR_DUTY:   read_data = {8'd0, duty_reg_q};
            ADDR_BLINK:  read_data = {24'd0, blink_q};
            ADDR_STATUS: read_data = {14'd0, ramp_down_q, trap_phase_q, level_q, 7'd0, blink_phase_q};
            default:     read_data = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         presc_q       <= 16'd0;
         pwm_ctr_q     <= 8'd0;
         duty_reg_q    <= 24'hFFFFFF;
         duty_act_q    <= 24'hFFFFFF;
         mode_q        <= MODE_SOLID;
         blink_q       <= 8'h20;
         blink_ctr_q   <= 8'd0;
         blink_phase_q <= 1'b0;
         level_q       <= 8'd0;
         ramp_down_q   <= 1'b0;
         trap_ctr_q    <= '0;
         trap_phase_q  <= 1'b0;
         pwm_q         <= 3'b000;
      end else begin
         presc_q       <= presc_d;
         pwm_ctr_q     <= pwm_ctr_d;
         duty_reg_q    <= duty_reg_d;
         duty_act_q    <= duty_act_d;
         mode_q        <= mode_d;
         blink_q       <= blink_d;
         blink_ctr_q   <= blink_ctr_d;
         blink_phase_q <= blink_phase_d;
         level_q       <= level_d;
         ramp_down_q   <= ramp_down_d;
         trap_ctr_q    <= trap_ctr_d;
         trap_phase_q  <= trap_phase_d;
         pwm_q         <= pwm_d;
      end
   end

   assign pwm_r = pwm_q[2];
   assign pwm_g = pwm_q[1];
   assign pwm_b = pwm_q[0];

endmodule

// File: tb/tb_tk1_led_pwm.sv
// Self-checking bench for tk1_led_pwm: register table, hand-written mode/trap/reset
// sequences and randomized traffic, all checked against a frame-arithmetic reference model.
module tb_tk1_led_pwm;

   localparam int PRESCALE    = 1;
   localparam int TRAP_FRAMES = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  led_en = 3'b000;
   logic        cpu_trap = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  address = 8'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready;
   logic        pwm_r, pwm_g, pwm_b;

   always #5 clk = ~clk;

   tk1_led_pwm #(.PRESCALE(PRESCALE), .TRAP_FRAMES(TRAP_FRAMES)) dut (
      .clk(clk), .reset_n(reset_n), .led_en(led_en), .cpu_trap(cpu_trap),
      .cs(cs), .we(we), .address(address), .write_data(write_data),
      .read_data(read_data), .ready(ready),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
   );

   int n_vec = 0;
   int n_fail = 0;
   int hr, hg, hb;
   logic [31:0] last_rd;

   // Reference model: time measured in cycles and frames since reset / last CTRL write.
   int          m_cyc, m_k, m_tf;
   logic [1:0]  m_mode;
   logic [23:0] m_duty_reg, m_duty_act;
   logic [7:0]  m_blink;

   task automatic model_reset();
      m_cyc = 0; m_k = 0; m_tf = 0; m_mode = 2'd0;
      m_duty_reg = 24'hFFFFFF; m_duty_act = 24'hFFFFFF; m_blink = 8'h20;
   endtask

   function automatic int m_level();
      int m = m_k % 512;
      return (m < 256) ? m : 511 - m;
   endfunction

   function automatic logic m_ramp();
      return (m_k % 512) >= 256;
   endfunction

   function automatic logic m_bphase();
      int b = (m_blink == 8'd0) ? 1 : int'(m_blink);
      return ((m_k / b) % 2) == 1;
   endfunction

   function automatic logic m_tphase();
      return ((m_tf / TRAP_FRAMES) % 2) == 1;
   endfunction

   function automatic int m_eff(input int duty);
      case (m_mode)
         2'd1:    return m_bphase() ? 0 : duty;
         2'd2:    return (duty * m_level()) / 256;
         default: return duty;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      logic [7:0] lv = 8'(m_level());
      case (a)
         8'h00:   return {30'd0, m_mode};
         8'h01:   return {8'd0, m_duty_reg};
         8'h02:   return {24'd0, m_blink};
         8'h03:   return {14'd0, m_ramp(), m_tphase(), lv, 7'd0, m_bphase()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive bus inputs, check combinational outputs, predict and check the registered PWM.
   task automatic do_cycle(input logic c, input logic w, input logic [7:0] a, input logic [31:0] d);
      int pc;
      logic fe;
      logic [2:0] exp;
      cs = c; we = w; address = a; write_data = d;
      #1;
      check("ready", {31'd0, ready}, {31'd0, c});
      last_rd = read_data;
      if (c && !w) check("read_data", read_data, m_read(a));
      pc = m_cyc % 256;
      if (!reset_n)      exp = 3'b000;
      else if (cpu_trap) exp = {m_tphase(), 2'b00};
      else               exp = {led_en[2] && pc < m_eff(int'(m_duty_act[23:16])),
                                led_en[1] && pc < m_eff(int'(m_duty_act[15:8])),
                                led_en[0] && pc < m_eff(int'(m_duty_act[7:0]))};
      if (!reset_n) begin
         model_reset();
      end else begin
         fe = (pc == 255);
         if (fe) m_duty_act = m_duty_reg;
         if (c && w && a == 8'h01) m_duty_reg = d[23:0];
         if (c && w && a == 8'h02) m_blink = d[7:0];
         if (c && w && a == 8'h00) begin m_mode = d[1:0]; m_k = 0; end
         else if (fe) m_k++;
         if (!cpu_trap) m_tf = 0;
         else if (fe) m_tf++;
         m_cyc++;
      end
      @(posedge clk);
      #1;
      check("pwm_rgb", {29'd0, pwm_r, pwm_g, pwm_b}, {29'd0, exp});
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic idle_to_frame_start();
      while (m_cyc % 256 != 0) do_cycle(1'b0, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic clear_counts();
      hr = 0; hg = 0; hb = 0;
   endtask

   // Full 256-cycle frame with a STATUS read at cycle 10.
   task automatic run_frame();
      for (int i = 0; i < 256; i++) begin
         if (i == 10) do_cycle(1'b1, 1'b0, 8'h03, 32'd0);
         else         do_cycle(1'b0, 1'b0, 8'd0, 32'd0);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [31:0] status_rd;
      model_reset();
      clear_counts();

      tbl[0]  = '{1'b0, 8'h01, 32'h0,        32'h00FFFFFF};
      tbl[1]  = '{1'b0, 8'h00, 32'h0,        32'h00000000};
      tbl[2]  = '{1'b0, 8'h02, 32'h0,        32'h00000020};
      tbl[3]  = '{1'b0, 8'h03, 32'h0,        32'h00000000};
      tbl[4]  = '{1'b0, 8'h05, 32'h0,        32'h00000000};
      tbl[5]  = '{1'b1, 8'h05, 32'hFFFFFFFF, 32'h0};
      tbl[6]  = '{1'b0, 8'h05, 32'h0,        32'h00000000};
      tbl[7]  = '{1'b1, 8'h00, 32'hFFFFFFFE, 32'h0};
      tbl[8]  = '{1'b0, 8'h00, 32'h0,        32'h00000002};
      tbl[9]  = '{1'b1, 8'h01, 32'hAABBCCDD, 32'h0};
      tbl[10] = '{1'b0, 8'h01, 32'h0,        32'h00BBCCDD};
      tbl[11] = '{1'b1, 8'h02, 32'h00001234, 32'h0};
      tbl[12] = '{1'b0, 8'h02, 32'h0,        32'h00000034};
      tbl[13] = '{1'b1, 8'h03, 32'hFFFFFFFF, 32'h0};
      tbl[14] = '{1'b0, 8'h01, 32'h0,        32'h00BBCCDD};
      tbl[15] = '{1'b1, 8'h02, 32'h00000000, 32'h0};
      tbl[16] = '{1'b0, 8'h02, 32'h0,        32'h00000000};

      // Reset state and register window
      do_reset();
      check("reset_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
      for (int i = 0; i < 17; i++) begin
         do_cycle(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         if (!tbl[i].we) check("tbl_read", last_rd, tbl[i].exp);
      end

      // Basic PWM duty counts
      do_reset();
      led_en = 3'b111;
      do_cycle(1'b1, 1'b1, 8'h01, 32'h00804000);
      idle_to_frame_start();
      clear_counts();
      idle(256);
      check("basic_r_highs", 32'(hr), 32'd128);
      check("basic_g_highs", 32'(hg), 32'd64);
      check("basic_b_highs", 32'(hb), 32'd0);

      // Duty shadowing: mid-frame write lands at the next frame
      do_reset();
      led_en = 3'b100;
      clear_counts();
      idle(100);
      do_cycle(1'b1, 1'b1, 8'h01, 32'h00100000);
      idle(155);
      check("shadow_old_frame", 32'(hr), 32'd255);
      clear_counts();
      idle(256);
      check("shadow_new_frame", 32'(hr), 32'd16);

      // BLINK with 2 frames per half-period
      do_reset();
      do_cycle(1'b1, 1'b1, 8'h02, 32'd2);
      do_cycle(1'b1, 1'b1, 8'h00, 32'd1);
      for (int f = 1; f <= 4; f++) begin
         idle_to_frame_start();
         clear_counts();
         run_frame();
         check("blink_r_highs", 32'(hr), ((f / 2) % 2 == 1) ? 32'd0 : 32'd255);
      end

      // BLINK=0 behaves as 1: phase flips every frame
      do_reset();
      do_cycle(1'b1, 1'b1, 8'h02, 32'd0);
      do_cycle(1'b1, 1'b1, 8'h00, 32'd1);
      for (int f = 1; f <= 3; f++) begin
         idle_to_frame_start();
         idle(10);
         do_cycle(1'b1, 1'b0, 8'h03, 32'd0);
         check("blink0_phase", {31'd0, last_rd[0]}, 32'(f % 2));
      end

      // BREATHE ramp up to level 128
      do_reset();
      do_cycle(1'b1, 1'b1, 8'h00, 32'd2);
      do_cycle(1'b1, 1'b0, 8'h03, 32'd0);
      check("breathe_level0", {24'd0, last_rd[15:8]}, 32'd0);
      for (int j = 1; j <= 128; j++) begin
         idle_to_frame_start();
         clear_counts();
         idle(10);
         do_cycle(1'b1, 1'b0, 8'h03, 32'd0);
         status_rd = last_rd;
         check("breathe_level", {24'd0, status_rd[15:8]}, 32'(j));
         idle(245);
         if (j == 128) check("breathe_r_highs_128", 32'(hr), 32'd127);
      end

      // Trap override
      do_reset();
      led_en = 3'b111;
      cpu_trap = 1'b1;
      clear_counts();
      idle(512);
      check("trap_r_low_half", 32'(hr), 32'd0);
      clear_counts();
      idle(512);
      check("trap_r_high_half", 32'(hr), 32'd512);
      check("trap_gb_highs", 32'(hg + hb), 32'd0);
      cpu_trap = 1'b0;
      idle(1);
      check("trap_release_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd7);
      do_cycle(1'b1, 1'b0, 8'h03, 32'd0);
      check("trap_phase_cleared", {31'd0, last_rd[16]}, 32'd0);

      // Reset asserted mid-frame
      do_cycle(1'b1, 1'b1, 8'h01, 32'h00123456);
      idle(50);
      reset_n = 1'b0;
      idle(1);
      check("midreset_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
      reset_n = 1'b1;
      do_cycle(1'b1, 1'b0, 8'h01, 32'd0);
      check("midreset_duty", last_rd, 32'h00FFFFFF);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 8000; n++) begin
         int op;
         op = $urandom_range(0, 99);
         if (op < 3) begin
            cpu_trap = ~cpu_trap;
            idle(1);
         end else if (op < 7) begin
            led_en = 3'($urandom_range(0, 7));
            idle(1);
         end else if (op < 13) begin
            do_cycle(1'b1, 1'b0, 8'($urandom_range(0, 7)), 32'd0);
         end else if (op < 16) begin
            do_cycle(1'b1, 1'b1, 8'h01, $urandom);
         end else if (op < 18) begin
            do_cycle(1'b1, 1'b1, 8'h00, $urandom);
         end else if (op < 20 && (m_cyc % 256) < 250) begin
            do_cycle(1'b1, 1'b1, 8'h02, 32'($urandom_range(0, 3)));
            do_cycle(1'b1, 1'b1, 8'h00, 32'($urandom_range(0, 3)));
         end else if (op == 20) begin
            do_cycle(1'b1, 1'b1, 8'($urandom_range(4, 255)), $urandom);
         end else if (op == 21 && $urandom_range(0, 9) == 0) begin
            do_reset();
         end else begin
            idle(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
